// File: rtl/rx_iq_serial_out.sv
// rx_iq_serial_out: buffers DDC I/Q pairs in a small FIFO and shifts each one out as a 64-bit sclk/fsync/sdata frame.
// Build macro RX_IQ_SEQ_EN: pad bytes carry a frame sequence count and {overflow, fifo_level}; otherwise pads are zero.
//
// state | meaning
// IDLE  | serializer quiet, waiting for enable and a stored pair
// SHIFT | frame in progress, one bit every 2*SCLK_DIV clocks
module rx_iq_serial_out #(
    parameter int FIFO_AW  = 4,
    parameter int SCLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_strobe,
    input  logic [23:0]      in_real,
    input  logic [23:0]      in_imag,
    input  logic             enable,
    input  logic             clear_ovf,
    output logic             sclk,
    output logic             fsync,
    output logic             sdata,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow,
    output logic             busy
);
    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       DIV_TC     = 8'(SCLK_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;

    // Strobe, data and clear are captured together so a clear and a drop seen at the ports in the same cycle collide here too.
    logic        strobe_q;
    logic        clear_q;
    logic [47:0] pair_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            clear_q  <= 1'b0;
            pair_q   <= '0;
        end else begin
            strobe_q <= in_strobe;
            clear_q  <= clear_ovf;
            pair_q   <= {in_real, in_imag};
        end
    end

    logic [47:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               full;
    logic               push;
    logic               drop;
    logic               pop;
    logic               can_start;
    logic [47:0]        head;

    assign full      = (fifo_level == LEVEL_FULL);
    assign push      = strobe_q && (!full || pop);
    assign drop      = strobe_q && full && !pop;
    assign can_start = enable && (fifo_level != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= pair_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_q) begin
                overflow <= 1'b0;
            end
        end
    end

    logic [7:0] pad_a;
    logic [7:0] pad_b;

`ifdef RX_IQ_SEQ_EN
    logic [7:0] seq_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seq_cnt <= 8'h00;
        end else if (pop) begin
            seq_cnt <= seq_cnt + 8'h01;
        end
    end

    assign pad_a = seq_cnt;
    assign pad_b = 8'({overflow, fifo_level});
`else
    assign pad_a = 8'h00;
    assign pad_b = 8'h00;
`endif

    logic [63:0] frame_load;
    assign frame_load = {head[47:24], pad_a, head[23:0], pad_b};

    logic [7:0]  div_cnt, div_nxt;
    logic [5:0]  bit_cnt, bit_nxt;
    logic [63:0] shreg, shreg_nxt;
    logic        sclk_nxt, sdata_nxt, fsync_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            shreg   <= '0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            fsync   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            sclk    <= sclk_nxt;
            sdata   <= sdata_nxt;
            fsync   <= fsync_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        sclk_nxt  = sclk;
        sdata_nxt = sdata;
        fsync_nxt = fsync;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                sclk_nxt  = 1'b0;
                sdata_nxt = 1'b0;
                fsync_nxt = 1'b0;
                if (can_start) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                    shreg_nxt = frame_load;
                    sdata_nxt = frame_load[63];
                    fsync_nxt = 1'b1;
                    bit_nxt   = 6'd63;
                    div_nxt   = 8'd0;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_TC) begin
                    div_nxt  = 8'd0;
                    sclk_nxt = ~sclk;
                    // Falling transition: present the next bit, or close the frame after bit 0.
                    if (sclk) begin
                        if (bit_cnt == 6'd0) begin
                            if (can_start) begin
                                pop       = 1'b1;
                                shreg_nxt = frame_load;
                                sdata_nxt = frame_load[63];
                                fsync_nxt = 1'b1;
                                bit_nxt   = 6'd63;
                            end else begin
                                state_nxt = IDLE;
                                sclk_nxt  = 1'b0;
                                sdata_nxt = 1'b0;
                                fsync_nxt = 1'b0;
                            end
                        end else begin
                            bit_nxt   = bit_cnt - 6'd1;
                            shreg_nxt = {shreg[62:0], 1'b0};
                            sdata_nxt = shreg[62];
                            fsync_nxt = (bit_cnt >= 6'd33);
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_rx_iq_serial_out.sv
// tb_rx_iq_serial_out: directed and randomized checks of rx_iq_serial_out against a time-based queue model.
// The model predicts every output each cycle from frame start time; a monitor reassembles frames on rising sclk.
module tb_rx_iq_serial_out;
`ifdef RX_IQ_SEQ_EN
    localparam int D        = 2;
    localparam int RAND_CYC = 1500;
    localparam logic [63:0] EXP_FRAME1 = 64'h12345600ABCDEF01;
    localparam logic [63:0] EXP_FRAME6 = 64'h00000100FFFFFF01;
`else
    localparam int D        = 4;
    localparam int RAND_CYC = 6000;
    localparam logic [63:0] EXP_FRAME1 = 64'h12345600ABCDEF00;
    localparam logic [63:0] EXP_FRAME6 = 64'h00000100FFFFFF00;
`endif
    localparam int DEPTH = 16;
    localparam int FRAME = 128 * D;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_strobe = 1'b0;
    logic [23:0] in_real = '0;
    logic [23:0] in_imag = '0;
    logic        enable = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        sclk, fsync, sdata, overflow, busy;
    logic [4:0]  fifo_level;

    rx_iq_serial_out #(.FIFO_AW(4), .SCLK_DIV(D)) dut (
        .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe),
        .in_real(in_real), .in_imag(in_imag), .enable(enable), .clear_ovf(clear_ovf),
        .sclk(sclk), .fsync(fsync), .sdata(sdata), .fifo_level(fifo_level),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference model: FIFO as a queue, serializer as "clocks left in the current frame".
    logic [47:0] m_q[$];
    int          m_rem = 0;
    bit          m_ovf = 0;
    int          m_seq = 0;
    logic [63:0] m_cur = '0;
    logic        m_sd = 0, m_cd = 0;
    logic [47:0] m_dd = '0;
    int          n_pop = 0;
    logic [63:0] exp_arr [1024];

    always @(posedge clock) begin
        int          old_size;
        bit          pop, drop;
        logic [47:0] p;
        logic [7:0]  pa, pb;
        if (!reset_n) begin
            m_q.delete();
            m_rem = 0; m_ovf = 0; m_seq = 0; m_cur = '0;
            m_sd = 0; m_cd = 0; m_dd = '0;
        end else begin
            old_size = m_q.size();
            pop  = enable && old_size != 0 && m_rem <= 1;
            drop = m_sd && old_size == DEPTH && !pop;
            if (pop) begin
                p  = m_q.pop_front();
                pa = 8'h00;
                pb = 8'h00;
`ifdef RX_IQ_SEQ_EN
                pa = 8'(m_seq);
                pb = 8'({m_ovf, 5'(old_size)});
`endif
                m_cur = {p[47:24], pa, p[23:0], pb};
                exp_arr[n_pop % 1024] = m_cur;
                n_pop++;
                m_seq++;
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (m_sd && !drop) m_q.push_back(m_dd);
            if (drop) m_ovf = 1;
            else if (m_cd) m_ovf = 0;
            m_sd = in_strobe;
            m_cd = clear_ovf;
            m_dd = {in_real, in_imag};
        end
    end

    // Monitor: per-cycle output prediction and frame reassembly on rising sclk.
    int          mon_bits = 0, n_rx = 0, rx_since_rst = 0, rx_total = 0;
    logic        prev_sclk = 0;
    logic [63:0] mon_sh = '0, mon_fs = '0, last_frame = '0;

    always @(negedge clock) begin
        int   e;
        logic esclk, efs, esd, ebusy;
        if (!reset_n) begin
            mon_bits = 0;
            rx_since_rst = 0;
            n_rx = n_pop;
        end else if (sclk && !prev_sclk) begin
            mon_sh = {mon_sh[62:0], sdata};
            mon_fs = {mon_fs[62:0], fsync};
            mon_bits++;
            if (mon_bits == 64) begin
                chk("frame", mon_sh, exp_arr[n_rx % 1024]);
                chk("fsync_pat", mon_fs, 64'hFFFF_FFFF_0000_0000);
`ifdef RX_IQ_SEQ_EN
                chk("pad_a", mon_sh[39:32], 8'(rx_since_rst));
`endif
                last_frame = mon_sh;
                n_rx++; rx_since_rst++; rx_total++;
                mon_bits = 0;
            end
        end
        prev_sclk = sclk;
        esclk = 0; efs = 0; esd = 0; ebusy = 0;
        if (m_rem > 0) begin
            e     = FRAME - m_rem;
            esclk = ((e / D) % 2) == 1;
            efs   = (e / (2 * D)) < 32;
            esd   = m_cur[63 - e / (2 * D)];
            ebusy = 1;
        end
        chk("outs", {sclk, fsync, sdata, busy, overflow, fifo_level},
            {esclk, efs, esd, ebusy, m_ovf, 5'(m_q.size())});
    end

    task automatic do_reset();
        reset_n = 0; in_strobe = 0; clear_ovf = 0; enable = 0;
        step(3);
        reset_n = 1;
        step(1);
    endtask

    task automatic strobe(input logic [23:0] i_val, input logic [23:0] q_val);
        in_real = i_val; in_imag = q_val; in_strobe = 1;
        step(1);
        in_strobe = 0;
    endtask

    initial begin
        int first_busy, first_rise, busy_cnt, f0;
        logic [4:0] lvl_at1;

        // Reset state and single-frame latency
        do_reset();
        chk("rst_level", fifo_level, 0);
        chk("rst_outs", {sclk, fsync, sdata, busy, overflow}, 0);
        enable = 1;
        strobe(24'h123456, 24'hABCDEF);
        first_busy = -1; first_rise = -1; busy_cnt = 0; lvl_at1 = '0;
        for (int i = 1; i <= FRAME + 80; i++) begin
            step(1);
            if (i == 1) lvl_at1 = fifo_level;
            if (busy && first_busy < 0) first_busy = i;
            if (sclk && first_rise < 0) first_rise = i;
            if (busy) busy_cnt++;
        end
        chk("lat_level", lvl_at1, 1);
        chk("lat_busy", first_busy, 2);
        chk("lat_sclk", first_rise, 2 + D);
        chk("busy_len", busy_cnt, FRAME);
        chk("frame1", last_frame, EXP_FRAME1);
        chk("idle_after", {sclk, fsync, sdata, busy, fifo_level}, 0);

        // Fill to saturation with enable low, then burst out back-to-back
        do_reset();
        for (int k = 0; k < 17; k++) begin
            strobe(24'($urandom), 24'($urandom));
            step(19);
        end
        chk("fill_level", fifo_level, 16);
        chk("fill_ovf", overflow, 1);
        f0 = rx_total;
        enable = 1;
        for (int i = 0; i < 16 * FRAME + 100 && rx_total - f0 < 16; i++) step(1);
        step(D + 5);
        chk("burst_frames", rx_total - f0, 16);
        chk("burst_level", fifo_level, 0);

        // Write accepted when it lands on the pop cycle of a full FIFO
        do_reset();
        for (int k = 0; k < 16; k++) begin
            strobe(24'($urandom), 24'($urandom));
            step(1);
        end
        step(2);
        chk("full_level", fifo_level, 16);
        in_real = 24'h0F0F0F; in_imag = 24'hF0F0F0; in_strobe = 1;
        step(1);
        in_strobe = 0; enable = 1;
        step(1);
        chk("pop_push_level", fifo_level, 16);
        chk("pop_push_ovf", overflow, 0);
        chk("pop_push_busy", busy, 1);

        // clear_ovf against a simultaneous drop
        do_reset();
        for (int k = 0; k < 16; k++) strobe(24'($urandom), 24'($urandom));
        step(2);
        chk("pre_ovf", overflow, 0);
        in_strobe = 1; clear_ovf = 1;
        step(1);
        in_strobe = 0; clear_ovf = 0;
        step(2);
        chk("set_wins", overflow, 1);
        chk("drop_level", fifo_level, 16);
        clear_ovf = 1;
        step(1);
        clear_ovf = 0;
        step(2);
        chk("ovf_cleared", overflow, 0);

        // Reset in the middle of bit 40, then a clean frame
        do_reset();
        enable = 1;
        strobe(24'hCAFE01, 24'h5A5A5A);
        step(1 + 47 * D);
        reset_n = 0;
        step(1);
        chk("abort_outs", {sclk, fsync, sdata, busy}, 0);
        chk("abort_level", fifo_level, 0);
        step(2);
        reset_n = 1;
        step(1);
        f0 = rx_total;
        strobe(24'h000001, 24'hFFFFFF);
        for (int i = 0; i < FRAME + 50 && rx_total == f0; i++) step(1);
        chk("post_abort_cnt", rx_total - f0, 1);
        chk("post_abort_frame", last_frame, EXP_FRAME6);

        // Randomized traffic, then drain
        do_reset();
        enable = 1;
        for (int i = 0; i < RAND_CYC; i++) begin
            in_strobe = ($urandom_range(0, 99) < ((i < RAND_CYC / 2) ? 8 : 1));
            in_real   = 24'($urandom);
            in_imag   = 24'($urandom);
            clear_ovf = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            step(1);
        end
        in_strobe = 0; clear_ovf = 0; enable = 1;
        step(17 * FRAME + 10);
        chk("drain_level", fifo_level, 0);
        chk("drain_busy", busy, 0);

`ifdef RX_IQ_SEQ_EN
        // Sequence counter wraps over 300 frames
        do_reset();
        enable = 1;
        for (int i = 0; i < 300 * FRAME + 2000 && rx_since_rst < 300; i++) begin
            in_strobe = (i % 100 == 0);
            in_real   = 24'($urandom);
            in_imag   = 24'($urandom);
            step(1);
        end
        in_strobe = 0;
        chk("seq_frames", rx_since_rst, 300);
        chk("seq_last_pad", last_frame[39:32], 8'd43);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
